// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: req/ack data-memory access with pipeline stall and beq/bne resolution.
// Optional access timeout is compiled in with `define MEM_TIMEOUT_EN.
module mem_access_unit #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              branch,
   input  logic              bne,
   input  logic              zero,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [DATA_W-1:0] write_data,
   output logic              stall,
   output logic              pc_src,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              addr_err,
   output logic              mem_err,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_load_data;
   logic              r_load_valid;
   logic              r_addr_err;
   logic              w_mem_op;
   logic              w_accept;
   logic              w_reject;
   logic              w_ack;
   logic              w_timeout;
   logic              w_leave;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("TIMEOUT_CYCLES must be >= 1");
   end

   assign w_mem_op = valid_in & (mem_read | mem_write);
   assign w_accept = w_mem_op & (mem_read ^ mem_write) & (alu_result[1:0] == 2'b00);
   assign w_reject = w_mem_op & ~w_accept;
   assign w_ack    = (r_state == S_ACCESS) & dmem_ack;
   assign w_leave  = w_ack | w_timeout;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_mem_err;

   // Counter holds the number of ACCESS cycles already spent; an ack in the last one still wins
   assign w_timeout = (r_state == S_ACCESS) & ~dmem_ack & (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_mem_err <= 1'b0;
      end else begin
         r_mem_err <= w_timeout;
         if (r_state == S_IDLE && w_accept)
            r_cnt <= '0;
         else if (r_state == S_ACCESS)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign mem_err = r_mem_err;
`else
   assign w_timeout = 1'b0;
   assign mem_err   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = S_ACCESS;
         S_ACCESS: if (w_leave)  w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      stall = 1'b0;
      case (r_state)
         S_IDLE:   stall = w_accept;
         S_ACCESS: stall = 1'b1;
         default:  stall = 1'b0;
      endcase
   end

   // Request fields are captured once on accept and stay frozen until the access ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_load_data  <= '0;
         r_load_valid <= 1'b0;
         r_addr_err   <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_accept) begin
            r_req   <= 1'b1;
            r_we    <= mem_write;
            r_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
            r_wdata <= write_data;
         end else if (w_leave) begin
            r_req <= 1'b0;
         end
         r_load_valid <= w_ack & ~r_we;
         if (w_ack && !r_we)
            r_load_data <= dmem_rdata;
         r_addr_err <= (r_state == S_IDLE) & w_reject;
      end
   end

   assign pc_src     = valid_in & branch & (bne ? ~zero : zero);
   assign dmem_req   = r_req;
   assign dmem_we    = r_we;
   assign dmem_addr  = r_addr;
   assign dmem_wdata = r_wdata;
   assign load_data  = r_load_data;
   assign load_valid = r_load_valid;
   assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected events, a monitor pops them.
module tb_mem_access_unit;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 16;
   localparam int K_REQ  = 0;
   localparam int K_LOAD = 1;
   localparam int K_AERR = 2;
   localparam int K_MERR = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_in, mem_read, mem_write, branch, bne, zero;
   logic [AW-1:0] alu_result;
   logic [DW-1:0] write_data;
   logic          stall, pc_src, load_valid, addr_err, mem_err;
   logic [DW-1:0] load_data;
   logic          dmem_req, dmem_we, dmem_ack;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata, dmem_rdata;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic        we;
   } ev_t;

   ev_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_read(mem_read),
      .mem_write(mem_write), .branch(branch), .bne(bne), .zero(zero),
      .alu_result(alu_result), .write_data(write_data), .stall(stall),
      .pc_src(pc_src), .load_data(load_data), .load_valid(load_valid),
      .addr_err(addr_err), .mem_err(mem_err), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic void push(input int k, input logic [31:0] a, input logic [31:0] d,
                                input logic we);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      e.we   = we;
      exp_q.push_back(e);
   endfunction

   task automatic got(input int k, input logic [31:0] a, input logic [31:0] d, input logic we);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d expected none", k);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", k, e.kind);
         if (k == K_REQ && e.kind == K_REQ) begin
            check("req_addr", a, e.addr);
            check("req_wdata", d, e.data);
            check("req_we", {31'd0, we}, {31'd0, e.we});
         end
         if (k == K_LOAD && e.kind == K_LOAD)
            check("load_data", d, e.data);
      end
   endtask

   logic prev_req = 1'b0;
   always @(negedge clk) begin
      if (dmem_req && !prev_req) got(K_REQ, dmem_addr, dmem_wdata, dmem_we);
      if (load_valid)            got(K_LOAD, 32'd0, load_data, 1'b0);
      if (addr_err)              got(K_AERR, 32'd0, 32'd0, 1'b0);
      if (mem_err)               got(K_MERR, 32'd0, 32'd0, 1'b0);
      prev_req = dmem_req;
   end

   task automatic idle_inputs();
      valid_in   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      bne        = 1'b0;
      zero       = 1'b0;
      alu_result = '0;
      write_data = '0;
   endtask

   // ack_cyc: ACCESS cycle (1-based) in which the memory acknowledges
   task automatic do_access(input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_cyc, input logic [31:0] rdata);
      int stalls = 0;
      @(posedge clk); #1;
      valid_in   = 1'b1;
      mem_read   = rd;
      mem_write  = ~rd;
      alu_result = addr;
      write_data = wd;
      push(K_REQ, addr, wd, ~rd);
      if (rd) push(K_LOAD, 32'd0, rdata, 1'b0);
      @(negedge clk);
      if (stall) stalls++;
      for (int k = 1; k <= ack_cyc; k++) begin
         @(posedge clk); #1;
         dmem_ack   = (k == ack_cyc);
         dmem_rdata = rdata;
         @(negedge clk);
         if (stall) stalls++;
         check("access_req_held", {31'd0, dmem_req}, 32'd1);
         check("access_addr_stable", dmem_addr, addr);
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      check("done_stall_low", {31'd0, stall}, 32'd0);
      check("done_req_low", {31'd0, dmem_req}, 32'd0);
      check("stall_cycles", stalls, ack_cyc + 1);
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic reject(input logic rd, input logic wr, input logic [31:0] addr);
      @(posedge clk); #1;
      valid_in   = 1'b1;
      mem_read   = rd;
      mem_write  = wr;
      alu_result = addr;
      push(K_AERR, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check("reject_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("reject_no_req", {31'd0, dmem_req}, 32'd0);
   endtask

   task automatic br(input logic v, input logic b, input logic is_bne, input logic z,
                     input logic exp);
      @(posedge clk); #1;
      valid_in = v;
      branch   = b;
      bne      = is_bne;
      zero     = z;
      @(negedge clk);
      check("pc_src", {31'd0, pc_src}, {31'd0, exp});
      check("branch_no_stall", {31'd0, stall}, 32'd0);
   endtask

   initial begin
      idle_inputs();
      rst_n      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_req", {31'd0, dmem_req}, 32'd0);
      check("rst_we", {31'd0, dmem_we}, 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_wdata", dmem_wdata, 32'd0);
      check("rst_load_data", load_data, 32'd0);
      check("rst_flags", {28'd0, load_valid, addr_err, mem_err, stall}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      do_access(1'b1, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
      do_access(1'b0, 32'h0000_0204, 32'h1234_5678, 4, 32'hAAAA_5555);
      do_access(1'b1, 32'h0000_0008, 32'h0, 2, 32'h0BAD_F00D);

      reject(1'b1, 1'b0, 32'h0000_0102);
      reject(1'b0, 1'b1, 32'h0000_0203);
      reject(1'b1, 1'b1, 32'h0000_0100);

      br(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      br(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      br(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      br(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      br(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      br(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      idle_inputs();

`ifdef MEM_TIMEOUT_EN
      begin
         int req_cyc = 0;
         logic seen_done = 1'b0;
         @(posedge clk); #1;
         valid_in   = 1'b1;
         mem_read   = 1'b1;
         alu_result = 32'h0000_0040;
         push(K_REQ, 32'h0000_0040, 32'h0, 1'b0);
         push(K_MERR, 32'd0, 32'd0, 1'b0);
         for (int i = 0; i < 3 * TO; i++) begin
            @(negedge clk);
            if (dmem_req) req_cyc++;
            if (!stall) begin
               seen_done = 1'b1;
               break;
            end
         end
         check("timeout_reached_done", {31'd0, seen_done}, 32'd1);
         check("timeout_req_cycles", req_cyc, TO);
         check("timeout_load_data_kept", load_data, 32'h0BAD_F00D);
         @(posedge clk); #1;
         idle_inputs();
      end
`endif

      @(posedge clk); #1;
      valid_in   = 1'b1;
      mem_read   = 1'b1;
      alu_result = 32'h0000_0300;
      push(K_REQ, 32'h0000_0300, 32'h0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("pre_reset_req", {31'd0, dmem_req}, 32'd1);
      #2;
      idle_inputs();
      rst_n = 1'b0;
      #1;
      check("async_reset_req", {31'd0, dmem_req}, 32'd0);
      check("async_reset_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      check("late_ack_no_load", {31'd0, load_valid}, 32'd0);
      check("late_ack_no_stall", {31'd0, stall}, 32'd0);
      check("late_ack_load_data", load_data, 32'd0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
